// File: rtl/krnl_cam_rtl_cam_engine.sv
// CAM engine for the CAM kernel datapath.
// Stores CAM_SIZE keys with valid bits. It supports bulk load (LANES keys per
// beat), single-entry write/invalidate, and a 3-stage lowest-index search
// with output backpressure.
// Optional build macro: CAM_MATCH_COUNT_EN. When defined, the result word
// also carries the number of matching entries in [2*INDEX_WIDTH+1:INDEX_WIDTH+1].

// One priority-encoder partition: finds the lowest set match bit and, when
// CAM_MATCH_COUNT_EN is defined, counts the set bits.
module krnl_cam_rtl_cam_engine_part #(
  parameter int PART   = 64,
  parameter int PIDX_W = 6,
  parameter int CNT_W  = 7
) (
  input  logic [PART-1:0]   match,
  output logic              hit,
  output logic [PIDX_W-1:0] idx,
  output logic [CNT_W-1:0]  cnt
);
  // Lowest-index encoder: scanning downward leaves the lowest hit in idx.
  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = PART - 1; i >= 0; i--)
      if (match[i]) idx = PIDX_W'(i);
  end

`ifdef CAM_MATCH_COUNT_EN
  // Popcount of this partition's matches.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < PART; i++) cnt = cnt + CNT_W'(match[i]);
  end
`else
  assign cnt = '0;
`endif
endmodule

module krnl_cam_rtl_cam_engine #(
  parameter int C_DATA_WIDTH  = 512,
  parameter int KEY_WIDTH     = 32,
  parameter int CAM_SIZE      = 256,
  parameter int LANES         = 16,
  parameter int DIVISION      = 4,
  parameter int OP_CODE_WIDTH = 3,
  parameter int INDEX_WIDTH   = $clog2(CAM_SIZE)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [OP_CODE_WIDTH-1:0] state,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [C_DATA_WIDTH-1:0]  s_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [C_DATA_WIDTH-1:0]  m_tdata,
  output logic                     update_all_end
);
  localparam int PART   = CAM_SIZE / DIVISION;
  localparam int PIDX_W = (PART > 1) ? $clog2(PART) : 1;
  localparam int CNT_W  = PIDX_W + 1;
  localparam int RES_W  = INDEX_WIDTH + 1;
  localparam int STAGES = 2;

  // Opcode 0 is IDLE: it accepts nothing and falls to the default branches.
  localparam logic [OP_CODE_WIDTH-1:0] OP_UPD_ALL = OP_CODE_WIDTH'(1);
  localparam logic [OP_CODE_WIDTH-1:0] OP_SEARCH  = OP_CODE_WIDTH'(2);
  localparam logic [OP_CODE_WIDTH-1:0] OP_UPD_ONE = OP_CODE_WIDTH'(3);

  logic                                 adv, acc;
  logic                                 upd_all_acc, upd_one_acc, search_acc, last_beat;
  logic [INDEX_WIDTH-1:0]               write_index;
  logic [INDEX_WIDTH-1:0]               one_idx;
  logic [CAM_SIZE-1:0][KEY_WIDTH-1:0]   key_mem;
  logic [CAM_SIZE-1:0]                  vld_mem;
  logic [CAM_SIZE-1:0]                  match;

  logic [STAGES:0]                      vld_pipe;  // [0]=S1 [1]=S2 [2]=output
  logic [STAGES-1:0]                    sts_pipe;  // status-word token alongside vld_pipe
  logic [KEY_WIDTH-1:0]                 s1_key;

  logic [DIVISION-1:0]                  part_hit, s2_hit;
  logic [DIVISION-1:0][PIDX_W-1:0]      part_idx, s2_idx;
  logic [DIVISION-1:0][CNT_W-1:0]       part_cnt;
  logic [RES_W-1:0]                     s3_idx;
  logic [C_DATA_WIDTH-1:0]              res_word;

  assign adv         = !m_tvalid || m_tready;
  assign acc         = s_tvalid && s_tready;
  assign upd_all_acc = acc && (state == OP_UPD_ALL);
  assign upd_one_acc = acc && (state == OP_UPD_ONE);
  assign search_acc  = acc && (state == OP_SEARCH);
  assign last_beat   = upd_all_acc && (write_index == INDEX_WIDTH'(CAM_SIZE - LANES));
  assign one_idx     = s_tdata[KEY_WIDTH +: INDEX_WIDTH];
  assign m_tvalid    = vld_pipe[STAGES];

  // Input ready: stream ops follow the output stall, single writes never stall.
  always_comb begin
    s_tready = 1'b0;
    if (aresetn) begin
      case (state)
        OP_UPD_ALL, OP_SEARCH: s_tready = adv;
        OP_UPD_ONE:            s_tready = 1'b1;
        default:               s_tready = 1'b0;
      endcase
    end
  end

  // Bulk-load cursor; any other opcode rewinds it to entry 0.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                 write_index <= '0;
    else if (state != OP_UPD_ALL) write_index <= '0;
    else if (upd_all_acc)         write_index <= last_beat ? '0 : write_index + INDEX_WIDTH'(LANES);
  end

  // Key storage carries no reset; the valid bits gate every match.
  always_ff @(posedge aclk) begin
    if (upd_all_acc) begin
      for (int l = 0; l < LANES; l++)
        key_mem[write_index + INDEX_WIDTH'(l)] <= s_tdata[l*KEY_WIDTH +: KEY_WIDTH];
    end else if (upd_one_acc) begin
      key_mem[one_idx] <= s_tdata[KEY_WIDTH-1:0];
    end
  end

  // Valid bits: a bulk load sets them; a single write sets or clears one.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_mem <= '0;
    end else if (upd_all_acc) begin
      for (int l = 0; l < LANES; l++)
        vld_mem[write_index + INDEX_WIDTH'(l)] <= 1'b1;
    end else if (upd_one_acc) begin
      vld_mem[one_idx] <= s_tdata[KEY_WIDTH + INDEX_WIDTH];
    end
  end

  // Compare the S1 key against every stored entry.
  always_comb begin
    for (int e = 0; e < CAM_SIZE; e++)
      match[e] = vld_mem[e] && (key_mem[e] == s1_key);
  end

  for (genvar p = 0; p < DIVISION; p++) begin : g_part
    krnl_cam_rtl_cam_engine_part #(.PART(PART), .PIDX_W(PIDX_W), .CNT_W(CNT_W)) u_part (
      .match (match[p*PART +: PART]),
      .hit   (part_hit[p]),
      .idx   (part_idx[p]),
      .cnt   (part_cnt[p])
    );
  end

  // Merge stage: the lowest non-empty partition wins; a miss is all ones.
  always_comb begin
    s3_idx = '1;
    for (int p = DIVISION - 1; p >= 0; p--)
      if (s2_hit[p]) s3_idx = {1'b0, INDEX_WIDTH'(p * PART) + INDEX_WIDTH'(s2_idx[p])};
  end

`ifdef CAM_MATCH_COUNT_EN
  logic [DIVISION-1:0][CNT_W-1:0] s2_cnt;
  logic [RES_W-1:0]               s3_cnt;

  // Sum the partition counts, saturating at the field width.
  always_comb begin
    int sum;
    sum = 0;
    for (int p = 0; p < DIVISION; p++) sum = sum + int'(s2_cnt[p]);
    s3_cnt = (sum > (2**RES_W - 1)) ? '1 : RES_W'(sum);
  end

  // S2 register for the partition counts.
  always_ff @(posedge aclk) begin
    if (adv) s2_cnt <= part_cnt;
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^part_cnt;
`endif

  // Result word: index field, plus the match count when it is built.
  always_comb begin
    res_word = '0;
    res_word[RES_W-1:0] = s3_idx;
`ifdef CAM_MATCH_COUNT_EN
    res_word[RES_W +: RES_W] = s3_cnt;
`endif
  end

  // Datapath stage registers; all of them hold while the output is stalled.
  always_ff @(posedge aclk) begin
    if (adv) begin
      s1_key <= s_tdata[KEY_WIDTH-1:0];
      s2_hit <= part_hit;
      s2_idx <= part_idx;
    end
  end

  // Valid/status shift register and output register; the end-of-load status
  // word rides the same pipeline, so it cannot collide with search results.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_pipe       <= '0;
      sts_pipe       <= '0;
      m_tdata        <= '0;
      update_all_end <= 1'b0;
    end else begin
      update_all_end <= last_beat;
      if (adv) begin
        vld_pipe <= {vld_pipe[STAGES-1:0], search_acc || last_beat};
        sts_pipe <= {sts_pipe[0], last_beat};
        if (vld_pipe[STAGES-1])
          m_tdata <= sts_pipe[STAGES-1] ? C_DATA_WIDTH'(100) : res_word;
      end
    end
  end
endmodule

// File: tb/tb_krnl_cam_rtl_cam_engine.sv
// Bench for krnl_cam_rtl_cam_engine: table of ops with expected results,
// a scoreboard queue drained by an output monitor, plus hand-written
// sequences for bulk load, backpressure, write-index rewind and reset.
module tb_krnl_cam_rtl_cam_engine;
  localparam logic [2:0] OP_IDLE = 3'd0, OP_UPD_ALL = 3'd1, OP_SEARCH = 3'd2, OP_UPD_ONE = 3'd3;
  localparam int MISS = 'h1FF;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [2:0]   state;
  logic         s_tvalid;
  logic         s_tready;
  logic [511:0] s_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic [511:0] m_tdata;
  logic         update_all_end;

  int tests = 0;
  int fails = 0;
  logic [511:0] sb[$];

  krnl_cam_rtl_cam_engine dut (
    .aclk(aclk), .aresetn(aresetn), .state(state),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .update_all_end(update_all_end)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [2:0] op;
    int key;
    int idx;
    bit v;
    int exp_idx;
    int exp_cnt;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [511:0] sw(input int idx, input int cnt);
    logic [511:0] w;
    w = '0;
    w[8:0] = idx[8:0];
`ifdef CAM_MATCH_COUNT_EN
    w[17:9] = cnt[8:0];
`else
    if (cnt < 0) w = '1;
`endif
    return w;
  endfunction

  function automatic logic [511:0] one_word(input int key, input int idx, input bit v);
    logic [511:0] d;
    d = '0;
    d[31:0]  = key;
    d[39:32] = idx[7:0];
    d[40]    = v;
    return d;
  endfunction

  function automatic logic [511:0] load_word(input int base);
    logic [511:0] d;
    d = '0;
    for (int l = 0; l < 16; l++) d[l*32 +: 32] = 32'(base + l);
    return d;
  endfunction

  // Output monitor: pops the scoreboard on each handshake and checks that a
  // stalled result is held unchanged.
  logic         stalled_prev = 1'b0;
  logic [511:0] held;
  always @(negedge aclk) begin
    if (aresetn) begin
      if (stalled_prev) begin
        tests++;
        if (!(m_tvalid && m_tdata == held)) begin
          fails++;
          $display("FAIL hold: valid=%0b data=%h want valid=1 data=%h", m_tvalid, m_tdata[31:0], held[31:0]);
        end
      end
      if (m_tvalid && m_tready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: data=%h with empty scoreboard", m_tdata[31:0]);
        end else begin
          logic [511:0] e;
          e = sb.pop_front();
          if (m_tdata !== e) begin
            fails++;
            $display("FAIL result: got %h want %h", m_tdata[31:0], e[31:0]);
          end
        end
      end
      stalled_prev = m_tvalid && !m_tready;
      held = m_tdata;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // Drive one beat, bounded wait for acceptance; enqueue exp on acceptance.
  task automatic send(input logic [2:0] op, input logic [511:0] d, input bit push, input logic [511:0] exp);
    bit ok;
    ok = 1'b0;
    state = op; s_tdata = d; s_tvalid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      #1;
      if (s_tready) begin
        ok = 1'b1;
        if (push) sb.push_back(exp);
      end
      @(posedge aclk); #1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: op=%0d not accepted within 50 cycles", op);
    end
  endtask

  task automatic idle();
    s_tvalid = 1'b0; state = OP_IDLE;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    tbl[0]  = '{OP_SEARCH,  1005,   0, 1'b0, 5,    1};
    tbl[1]  = '{OP_SEARCH,  1255,   0, 1'b0, 255,  1};
    tbl[2]  = '{OP_SEARCH,  7,      0, 1'b0, MISS, 0};
    tbl[3]  = '{OP_UPD_ONE, 1255,   5, 1'b1, 0,    0};
    tbl[4]  = '{OP_SEARCH,  1255,   0, 1'b0, 5,    2};
    tbl[5]  = '{OP_SEARCH,  1005,   0, 1'b0, MISS, 0};
    tbl[6]  = '{OP_UPD_ONE, 1255,   5, 1'b0, 0,    0};
    tbl[7]  = '{OP_SEARCH,  1255,   0, 1'b0, 255,  1};
    tbl[8]  = '{OP_UPD_ONE, 1255,   0, 1'b1, 0,    0};
    tbl[9]  = '{OP_SEARCH,  1255,   0, 1'b0, 0,    2};
    tbl[10] = '{OP_UPD_ONE, 42,   255, 1'b1, 0,    0};
    tbl[11] = '{OP_SEARCH,  42,     0, 1'b0, 255,  1};

    aresetn = 1'b1; state = OP_SEARCH; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    #2 aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tdata", m_tdata[31:0], 32'd0);
    check("rst_update_all_end", 32'(update_all_end), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    aresetn = 1'b1; idle();
    @(posedge aclk); #1;

    // Empty CAM: invalid entries never match.
    send(OP_SEARCH, 512'd0, 1'b1, sw(MISS, 0));
    idle();

    // Bulk load: entry i holds 1000+i; status word after the final beat.
    for (int b = 0; b < 16; b++) begin
      send(OP_UPD_ALL, load_word(1000 + 16*b), (b == 15), 512'd100);
      check($sformatf("update_all_end_b%0d", b), 32'(update_all_end), 32'(b == 15));
    end
    idle();
    @(posedge aclk); #1;
    check("update_all_end_pulse", 32'(update_all_end), 32'd0);

    // Table vectors, one beat per cycle.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].op == OP_SEARCH)
        send(OP_SEARCH, 512'(tbl[i].key), 1'b1, sw(tbl[i].exp_idx, tbl[i].exp_cnt));
      else
        send(OP_UPD_ONE, one_word(tbl[i].key, tbl[i].idx, tbl[i].v), 1'b0, '0);
    end
    idle();

    // Back-to-back searches with a 4-cycle downstream stall mid-stream.
    fork
      begin
        for (int k = 0; k < 12; k++)
          send(OP_SEARCH, 512'(1016 + k), 1'b1, sw(16 + k, 1));
        idle();
      end
      begin
        repeat (5) @(posedge aclk);
        #1 m_tready = 1'b0;
        #1;
        check("stall_s_tready", 32'(s_tready), 32'd0);
        check("stall_m_tvalid", 32'(m_tvalid), 32'd1);
        repeat (4) @(posedge aclk);
        #1 m_tready = 1'b1;
      end
    join

    // Wrap after a full load: next beat lands at entry 0.
    send(OP_UPD_ALL, load_word(5000), 1'b0, '0);
    send(OP_SEARCH, 512'd5003, 1'b1, sw(3, 1));
    send(OP_SEARCH, 512'd1003, 1'b1, sw(MISS, 0));
    send(OP_SEARCH, 512'd1020, 1'b1, sw(20, 1));
    // Leaving UPDATE_ALL mid-load rewinds the cursor but keeps entries.
    send(OP_UPD_ALL, load_word(6000), 1'b0, '0);
    send(OP_SEARCH, 512'd6000, 1'b1, sw(0, 1));
    send(OP_SEARCH, 512'd5000, 1'b1, sw(MISS, 0));
    send(OP_SEARCH, 512'd1016, 1'b1, sw(16, 1));
    idle();
    for (int c = 0; c < 100 && sb.size() != 0; c++) @(posedge aclk);
    #1;

    // Reset mid-load (write_index=64) with searches in flight.
    for (int b = 0; b < 4; b++) send(OP_UPD_ALL, load_word(7000 + 16*b), 1'b0, '0);
    for (int k = 0; k < 3; k++) send(OP_SEARCH, 512'(7000 + k), 1'b0, '0);
    check("inflight_m_tvalid", 32'(m_tvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_m_tdata", m_tdata[31:0], 32'd0);
    idle();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    send(OP_SEARCH, 512'd7000, 1'b1, sw(MISS, 0));
    send(OP_SEARCH, 512'd1020, 1'b1, sw(MISS, 0));
    send(OP_SEARCH, 512'd6001, 1'b1, sw(MISS, 0));
    idle();

    for (int c = 0; c < 100 && sb.size() != 0; c++) @(posedge aclk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
